// File: rtl/sandpile_pkg.sv
// Shared types and constants for the sandpile grid engine.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package sandpile_pkg;

    typedef logic [2:0] cell_t;

    localparam int TOPPLE_THRESHOLD = 4;
    localparam int CELL_MAX         = 7;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DROP,
        SCAN
    } engine_state_t;

    // Add one grain, holding at CELL_MAX so a full cell never wraps to empty.
    function automatic cell_t sat_inc(cell_t c);
        return (c == cell_t'(CELL_MAX)) ? c : c + cell_t'(1);
    endfunction

endpackage

// File: rtl/sandpile_grid_engine_if.sv
// Control and renderer-read bundle between the input/control logic, the VGA
// renderer (master side) and the sandpile engine (slave side).
// Latency: n/a (wiring only). Backpressure: none; the read port is always available.
// Members: grid_size, drop_req, clear_req, grid_addr_x, grid_addr_y (to engine);
//          grid_data, busy, stable, topple_count (from engine).
interface sandpile_grid_engine_if #(
    parameter int MAX_SIZE = 32
);
    localparam int AW = $clog2(MAX_SIZE);

    logic [8:0]    grid_size;
    logic          drop_req;
    logic          clear_req;
    logic [AW-1:0] grid_addr_x;
    logic [AW-1:0] grid_addr_y;
    logic [2:0]    grid_data;
    logic          busy;
    logic          stable;
    logic [15:0]   topple_count;

    modport master (
        output grid_size, drop_req, clear_req, grid_addr_x, grid_addr_y,
        input  grid_data, busy, stable, topple_count
    );

    modport slave (
        input  grid_size, drop_req, clear_req, grid_addr_x, grid_addr_y,
        output grid_data, busy, stable, topple_count
    );

endinterface

// File: rtl/sandpile_scan_counter.sv
// Raster-order (x fastest) cell position counter that wraps at edge length n.
// Latency: position updates on the edge after advance/restart; last_cell is combinational.
// Backpressure: holds position while advance is low; restart overrides advance.
// Ports: clk, rst_n, n (edge length), restart, advance -> x, y, last_cell.
module sandpile_scan_counter #(
    parameter int MAX_SIZE = 32,
    parameter int AW       = $clog2(MAX_SIZE),
    parameter int NW       = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NW-1:0] n,
    input  logic          restart,
    input  logic          advance,
    output logic [AW-1:0] x,
    output logic [AW-1:0] y,
    output logic          last_cell
);

    logic x_last;
    logic y_last;

    assign x_last    = ({1'b0, x} == n - NW'(1));
    assign y_last    = ({1'b0, y} == n - NW'(1));
    assign last_cell = x_last && y_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (restart) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + AW'(1);
            end else begin
                x <= x + AW'(1);
            end
        end
    end

endmodule

// File: rtl/sandpile_grid_engine.sv
// Abelian sandpile grid: flop storage, centre drops, raster toppling sweeps to stability.
// Latency: renderer read 1 cycle; drop -> DROP 1 cycle after pending, then sweeps x n*n cycles.
// Backpressure: none; one pending drop is remembered, extra requests while pending are lost.
// Ports: clk, rst_n, bus (sandpile_grid_engine_if.slave).
// Optional: define SANDPILE_TOPPLE_COUNTER_EN to build the saturating topple counter.
module sandpile_grid_engine
    import sandpile_pkg::*;
#(
    parameter int MAX_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sandpile_grid_engine_if.slave  bus
);

    localparam int AW = $clog2(MAX_SIZE);
    localparam int NW = AW + 1;

    cell_t         cells [MAX_SIZE][MAX_SIZE];
    engine_state_t state, state_n;

    logic [NW-1:0] n_reg;
    logic [NW-1:0] n_clamped;
    logic          drop_pend;
    logic          sweep_flag;
    logic          stable_r;
    logic [2:0]    grid_data_r;

    logic [AW-1:0] sx, sy;
    logic [AW-1:0] sx_m, sx_p, sy_m, sy_p;
    logic [AW-1:0] centre;
    logic          last_cell;
    logic          consume;
    logic          accept;
    logic          topple_now;
    cell_t         cur;

    assign n_clamped = (bus.grid_size > 9'(MAX_SIZE)) ? NW'(MAX_SIZE) : bus.grid_size[NW-1:0];

    // A pending drop is consumed in IDLE whether or not it does anything;
    // with no grid it just evaporates.
    assign consume = (state == IDLE) && drop_pend && !bus.clear_req;
    assign accept  = consume && (bus.grid_size != 9'd0);

    assign centre     = AW'(n_reg >> 1);
    assign cur        = cells[sy][sx];
    assign topple_now = (state == SCAN) && (cur >= cell_t'(TOPPLE_THRESHOLD));

    assign sx_m = sx - AW'(1);
    assign sx_p = sx + AW'(1);
    assign sy_m = sy - AW'(1);
    assign sy_p = sy + AW'(1);

    sandpile_scan_counter #(
        .MAX_SIZE (MAX_SIZE)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .n         (n_reg),
        .restart   (state == DROP),
        .advance   (state == SCAN),
        .x         (sx),
        .y         (sy),
        .last_cell (last_cell)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.clear_req) begin
            state_n = CLEAR;
        end else begin
            case (state)
                IDLE:    if (accept) state_n = DROP;
                CLEAR:   state_n = IDLE;
                DROP:    state_n = SCAN;
                // The topple happening on the last cell itself also forces another sweep.
                SCAN:    if (last_cell && !(sweep_flag || topple_now)) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Grid storage. Neighbour writes never alias the centre cell or each other,
    // so all five updates of a topple land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_SIZE; i++)
                for (int j = 0; j < MAX_SIZE; j++)
                    cells[i][j] <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    for (int i = 0; i < MAX_SIZE; i++)
                        for (int j = 0; j < MAX_SIZE; j++)
                            cells[i][j] <= '0;
                end
                DROP: cells[centre][centre] <= sat_inc(cells[centre][centre]);
                SCAN: begin
                    if (topple_now) begin
                        cells[sy][sx] <= cur - cell_t'(TOPPLE_THRESHOLD);
                        if (sx != '0)
                            cells[sy][sx_m] <= sat_inc(cells[sy][sx_m]);
                        if (({1'b0, sx} + NW'(1)) < n_reg)
                            cells[sy][sx_p] <= sat_inc(cells[sy][sx_p]);
                        if (sy != '0)
                            cells[sy_m][sx] <= sat_inc(cells[sy_m][sx]);
                        if (({1'b0, sy} + NW'(1)) < n_reg)
                            cells[sy_p][sx] <= sat_inc(cells[sy_p][sx]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pend   <= 1'b0;
            n_reg       <= '0;
            sweep_flag  <= 1'b0;
            stable_r    <= 1'b1;
            grid_data_r <= '0;
        end else begin
            drop_pend <= (state == CLEAR || consume) ? 1'b0 : (drop_pend | bus.drop_req);

            if (accept) begin
                n_reg    <= n_clamped;
                stable_r <= 1'b0;
            end else if (state == SCAN && state_n == IDLE) begin
                stable_r <= 1'b1;
            end

            if (state == DROP)
                sweep_flag <= 1'b0;
            else if (state == SCAN) begin
                if (last_cell)       sweep_flag <= 1'b0;
                else if (topple_now) sweep_flag <= 1'b1;
            end

            // Read port is independent of the sweep and sees mid-sweep values.
            grid_data_r <= ({1'b0, bus.grid_addr_x} < n_reg && {1'b0, bus.grid_addr_y} < n_reg)
                           ? cells[bus.grid_addr_y][bus.grid_addr_x] : 3'd0;
        end
    end

    assign bus.grid_data = grid_data_r;
    assign bus.busy      = (state != IDLE);
    assign bus.stable    = stable_r;

`ifdef SANDPILE_TOPPLE_COUNTER_EN
    logic [15:0] topple_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            topple_cnt <= '0;
        else if (state == CLEAR)
            topple_cnt <= '0;
        else if (topple_now && topple_cnt != 16'hFFFF)
            topple_cnt <= topple_cnt + 16'd1;
    end

    assign bus.topple_count = topple_cnt;
`else
    assign bus.topple_count = '0;
`endif

endmodule

// File: tb/tb_sandpile_grid_engine.sv
// Directed bench for sandpile_grid_engine with a queue-based scoreboard.
// Stimulus pushes expected values; a negedge monitor pops them one cycle after issue.
// Ports: none (top-level bench).
module tb_sandpile_grid_engine;

    localparam int MS = 32;
    localparam int K_DATA   = 0;
    localparam int K_BUSY   = 1;
    localparam int K_STABLE = 2;
    localparam int K_TOPPLE = 3;

`ifdef SANDPILE_TOPPLE_COUNTER_EN
    localparam int CNT_ONE = 1;
`else
    localparam int CNT_ONE = 0;
`endif

    typedef struct {
        int kind;
        int x;
        int y;
        int exp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sandpile_grid_engine_if #(.MAX_SIZE(MS)) bus();

    sandpile_grid_engine #(.MAX_SIZE(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    logic rd_issue = 1'b0;
    logic rd_pipe  = 1'b0;
    exp_t e;
    int   act;
    int   g [5][5];

    function automatic string kname(int k);
        case (k)
            K_DATA:   return "grid_data";
            K_BUSY:   return "busy";
            K_STABLE: return "stable";
            default:  return "topple_count";
        endcase
    endfunction

    // A request issued before edge k is answered after edge k.
    always @(posedge clk) rd_pipe <= rd_issue;

    always @(negedge clk) begin
        if (rd_pipe) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow: response with no expected entry");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_DATA:   act = int'(bus.grid_data);
                    K_BUSY:   act = int'(bus.busy);
                    K_STABLE: act = int'(bus.stable);
                    default:  act = int'(bus.topple_count);
                endcase
                if (act != e.exp) begin
                    fails++;
                    $display("FAIL %s(%0d,%0d): got %0d expected %0d",
                             kname(e.kind), e.x, e.y, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input int x, input int y, input int exp);
        exp_t t;
        t.kind = kind; t.x = x; t.y = y; t.exp = exp;
        bus.grid_addr_x = 5'(x);
        bus.grid_addr_y = 5'(y);
        sb.push_back(t);
        rd_issue = 1'b1;
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 3000) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            checks++;
            fails++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    task automatic drop_op();
        bus.drop_req = 1'b1;
        tick();
        bus.drop_req = 1'b0;
        tick();
        tick();
        wait_idle();
    endtask

    task automatic clear_op();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.grid_size   = 9'd0;
        bus.drop_req    = 1'b0;
        bus.clear_req   = 1'b0;
        bus.grid_addr_x = '0;
        bus.grid_addr_y = '0;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        expect_val(K_DATA, 3, 4, 0);
        expect_val(K_BUSY, 0, 0, 0);
        expect_val(K_STABLE, 0, 0, 1);
        expect_val(K_TOPPLE, 0, 0, 0);

        // 5x5, three drops: no topple yet
        clear_op();
        bus.grid_size = 9'd5;
        repeat (3) drop_op();
        expect_val(K_DATA, 2, 2, 3);
        expect_val(K_DATA, 1, 2, 0);
        expect_val(K_STABLE, 0, 0, 1);
        expect_val(K_TOPPLE, 0, 0, 0);

        // Fourth drop: centre topples once into its four neighbours
        drop_op();
        for (int yy = 0; yy < 5; yy++)
            for (int xx = 0; xx < 5; xx++)
                g[yy][xx] = 0;
        g[2][1] = 1; g[2][3] = 1; g[1][2] = 1; g[3][2] = 1;
        for (int yy = 0; yy < 6; yy++)
            for (int xx = 0; xx < 6; xx++)
                expect_val(K_DATA, xx, yy, (xx < 5 && yy < 5) ? g[yy][xx] : 0);
        expect_val(K_TOPPLE, 0, 0, CNT_ONE);
        expect_val(K_STABLE, 0, 0, 1);
        expect_val(K_BUSY, 0, 0, 0);

        // 1x1: every toppled grain falls off the edge
        clear_op();
        expect_val(K_DATA, 2, 1, 0);
        bus.grid_size = 9'd1;
        repeat (3) drop_op();
        expect_val(K_DATA, 0, 0, 3);
        drop_op();
        expect_val(K_DATA, 0, 0, 0);
        expect_val(K_DATA, 1, 0, 0);
        expect_val(K_TOPPLE, 0, 0, CNT_ONE);
        expect_val(K_STABLE, 0, 0, 1);

        // grid_size 0: drop is discarded, and stays discarded once a grid appears
        bus.grid_size = 9'd0;
        bus.drop_req  = 1'b1;
        tick();
        bus.drop_req  = 1'b0;
        expect_val(K_BUSY, 0, 0, 0);
        expect_val(K_BUSY, 0, 0, 0);
        bus.grid_size = 9'd5;
        tick();
        expect_val(K_BUSY, 0, 0, 0);
        expect_val(K_DATA, 0, 0, 0);
        expect_val(K_STABLE, 0, 0, 1);

        // 3x3: clear aborts a sweep in progress
        clear_op();
        bus.grid_size = 9'd3;
        repeat (11) drop_op();
        bus.drop_req = 1'b1;
        tick();
        bus.drop_req = 1'b0;
        tick();
        tick();
        expect_val(K_BUSY, 0, 0, 1);
        bus.clear_req = 1'b1;
        expect_val(K_BUSY, 0, 0, 1);
        bus.clear_req = 1'b0;
        expect_val(K_BUSY, 0, 0, 0);
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 3; xx++)
                expect_val(K_DATA, xx, yy, 0);
        expect_val(K_TOPPLE, 0, 0, 0);
        expect_val(K_BUSY, 0, 0, 0);

        tick();
        tick();
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
